// File: rtl/uart_pkg.sv
// Shared UART definitions: RX write-FSM state encodings, default byte width
// and the saturating add used by the statistics counters.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE_RX    = 3'd0,
    CHECK_FULL = 3'd1,
    ASSERT_WR  = 3'd2,
    DROP_BYTE  = 3'd3
  } rx_state_e;

  // Adds 0..3 to val and clamps at max_val, so counters never wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [1:0]  inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, val} + {31'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/uart_rx_skid_buf.sv
// One-entry holding register for a byte plus its frame-error bit.
// A push in the same cycle as a pop refills the entry with the new byte.
module uart_rx_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_err,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  // Entry register; push has priority so a simultaneous pop+push stays full.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      full <= 1'b0;
      data <= '0;
      err  <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
      err  <= push_err;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_wr_fsm.sv
// Moves received UART bytes into the RX FIFO, one write-enable pulse per byte.
// A one-entry skid buffer absorbs a byte arriving mid-write; bytes are dropped
// on FIFO full, frame error or skid overflow. Also keeps saturating write/drop
// counters, a sticky overflow flag and an idle-timeout end-of-burst pulse.
module uart_rx_fifo_wr_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_rx_data_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_frame_err,
  input  logic              i_fifo_full,
  input  logic              i_cnt_clr,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [CNT_W-1:0]  o_wr_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic              o_overflow,
  output logic              o_burst_end
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam int          TW      = $clog2(IDLE_TIMEOUT);

  rx_state_e         state, state_nxt;
  logic [DATA_W-1:0] hold;
  logic              hold_err;      // byte under processing had a frame error
  logic              load_new, load_skid;
  logic              skid_push, skid_pop, skid_ovf;
  logic              skid_full, skid_err;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        drop_inc;
  logic              ovf_set;
  logic              burst_act, idle_quiet;
  logic [TW-1:0]     tcnt;

  uart_rx_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk       (i_clk),
    .rstn      (i_rstn),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (i_rx_data),
    .push_err  (i_rx_frame_err),
    .full      (skid_full),
    .data      (skid_data),
    .err       (skid_err)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE_RX;
    else         state <= state_nxt;
  end

  // Next state and skid control. The skid byte is older, so in IDLE_RX it is
  // served first and any new byte takes its place in the buffer.
  always_comb begin
    state_nxt = state;
    load_new  = 1'b0;
    load_skid = 1'b0;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    skid_ovf  = 1'b0;
    case (state)
      IDLE_RX: begin
        if (skid_full) begin
          load_skid = 1'b1;
          skid_pop  = 1'b1;
          skid_push = i_rx_data_valid;
          state_nxt = skid_err ? DROP_BYTE : CHECK_FULL;
        end else if (i_rx_data_valid) begin
          load_new  = 1'b1;
          state_nxt = i_rx_frame_err ? DROP_BYTE : CHECK_FULL;
        end
      end
      // UART bytes cannot be back-pressured: decide immediately.
      CHECK_FULL: state_nxt = i_fifo_full ? DROP_BYTE : ASSERT_WR;
      ASSERT_WR:  state_nxt = IDLE_RX;
      DROP_BYTE:  state_nxt = IDLE_RX;
      default:    state_nxt = IDLE_RX;
    endcase
    if (state != IDLE_RX && i_rx_data_valid) begin
      if (skid_full) skid_ovf  = 1'b1;
      else           skid_push = 1'b1;
    end
  end

  // Hold register: only good bytes are captured; error flag follows every load.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hold     <= '0;
      hold_err <= 1'b0;
    end else if (load_skid) begin
      hold_err <= skid_err;
      if (!skid_err) hold <= skid_data;
    end else if (load_new) begin
      hold_err <= i_rx_frame_err;
      if (!i_rx_frame_err) hold <= i_rx_data;
    end
  end

  assign o_wr_en   = (state == ASSERT_WR);
  assign o_wr_data = hold;

  assign drop_inc = {1'b0, state == DROP_BYTE} + {1'b0, skid_ovf};
  assign ovf_set  = (state == DROP_BYTE && !hold_err) || skid_ovf;

  // Saturating statistics; clear beats any same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_cnt_clr) begin
      o_wr_cnt   <= '0;
      o_drop_cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_wr_cnt   <= CNT_W'(sat_add(32'(o_wr_cnt), {1'b0, o_wr_en}, CNT_MAX));
      o_drop_cnt <= CNT_W'(sat_add(32'(o_drop_cnt), drop_inc, CNT_MAX));
      if (ovf_set) o_overflow <= 1'b1;
    end
  end

  assign idle_quiet = state == IDLE_RX && !skid_full && !i_rx_data_valid;

  // Burst tracker: armed by a written byte, counts truly idle cycles, any RX
  // valid restarts the count, and the terminal count fires o_burst_end.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      burst_act   <= 1'b0;
      tcnt        <= '0;
      o_burst_end <= 1'b0;
    end else begin
      o_burst_end <= 1'b0;
      if (o_wr_en) begin
        burst_act <= 1'b1;
        tcnt      <= '0;
      end else if (burst_act) begin
        if (i_rx_data_valid) begin
          tcnt <= '0;
        end else if (idle_quiet) begin
          if (tcnt == TW'(IDLE_TIMEOUT - 1)) begin
            o_burst_end <= 1'b1;
            burst_act   <= 1'b0;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_wr_fsm.sv
// Randomized + directed bench. A timestamp model (processor busy-until time,
// one pending slot) predicts each FIFO write and burst-end pulse with its
// cycle; a monitor pops and compares them as the DUT presents them.
module tb_uart_rx_fifo_wr_fsm;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int TO = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_valid = 1'b0, rx_err = 1'b0, fifo_full = 1'b0, cnt_clr = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          wr_en, overflow, burst_end;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] wr_cnt, drop_cnt;

  uart_rx_fifo_wr_fsm #(.DATA_W(DW), .CNT_W(CW), .IDLE_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx_data_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_frame_err(rx_err), .i_fifo_full(fifo_full), .i_cnt_clr(cnt_clr),
    .o_wr_en(wr_en), .o_wr_data(wr_data), .o_wr_cnt(wr_cnt), .o_drop_cnt(drop_cnt),
    .o_overflow(overflow), .o_burst_end(burst_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int t; } wr_t;
  wr_t exp_wr[$];
  int  exp_be[$];
  int  checks = 0, errors = 0, burst_seen = 0;

  // Reference model state.
  int            free_at = 0;          // first cycle the byte processor is free
  bit            pv = 0;  logic [DW-1:0] pd; bit pe;   // waiting byte
  bit            fv = 0;  int fstart;  logic [DW-1:0] fd; bit fe;  // byte in flight
  int            acc_at = -1;
  bit            bact = 0; int brun = 0;
  int            mw = 0, md = 0; bit mov = 0;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic void start(input logic [DW-1:0] d, input bit e, input int t);
    fv = 1; fd = d; fe = e; fstart = t;
    free_at = t + (e ? 2 : 3);
  endfunction

  function automatic void model(input bit v, input logic [DW-1:0] d, input bit e,
                                input bit f, input bit c, input int t);
    bit idle_now;
    if (fv && t == fstart + 1) begin
      if (fe)     md++;
      else if (f) begin md++; mov = 1; end
      else begin
        exp_wr.push_back('{d: fd, t: t + 1});
        mw++; acc_at = t + 1;
      end
      fv = 0;
    end
    idle_now = (t >= free_at) && !pv;
    if (t == acc_at) begin bact = 1; brun = 0; end
    else if (bact) begin
      if (v) brun = 0;
      else if (idle_now) begin
        if (brun == TO - 1) begin exp_be.push_back(t + 1); bact = 0; brun = 0; end
        else brun++;
      end
    end
    if (t >= free_at) begin
      if (pv) begin
        start(pd, pe, t); pv = 0;
        if (v) begin pv = 1; pd = d; pe = e; end
      end else if (v) start(d, e, t);
    end else if (v) begin
      if (!pv) begin pv = 1; pd = d; pe = e; end
      else begin md++; mov = 1; end
    end
    if (c) begin mw = 0; md = 0; mov = 0; end
  endfunction

  function automatic void model_reset(input int t);
    free_at = t; pv = 0; fv = 0; acc_at = -1; bact = 0; brun = 0;
    mw = 0; md = 0; mov = 0;
    exp_wr.delete(); exp_be.delete();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit e,
                      input bit f, input bit c);
    rx_valid = v; rx_data = d; rx_err = e; fifo_full = f; cnt_clr = c;
    model(v, d, e, f, c, cyc);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, 0);
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, " wr_cnt"},   32'(wr_cnt),   32'(sat(mw)));
    chk({nm, " drop_cnt"}, 32'(drop_cnt), 32'(sat(md)));
    chk({nm, " overflow"}, 32'(overflow), 32'(mov));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " wr_en"},     32'(wr_en),     0);
    chk({nm, " wr_data"},   32'(wr_data),   0);
    chk({nm, " wr_cnt"},    32'(wr_cnt),    0);
    chk({nm, " drop_cnt"},  32'(drop_cnt),  0);
    chk({nm, " overflow"},  32'(overflow),  0);
    chk({nm, " burst_end"}, 32'(burst_end), 0);
  endtask

  // Monitor: every write / burst pulse must match the next prediction.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++; $display("FAIL wr_unexpected: data %0h at cycle %0d, none expected", wr_data, cyc);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (wr_data !== e.d || cyc != e.t) begin
          errors++;
          $display("FAIL wr_data: got %0h at cycle %0d expected %0h at cycle %0d", wr_data, cyc, e.d, e.t);
        end
      end
    end
    if (burst_end === 1'b1) begin
      burst_seen++; checks++;
      if (exp_be.size() == 0) begin
        errors++; $display("FAIL burst_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int et;
        et = exp_be.pop_front();
        if (cyc != et) begin
          errors++; $display("FAIL burst_end: pulse at cycle %0d expected cycle %0d", cyc, et);
        end
      end
    end
  end

  initial begin
    int bs;
    repeat (2) @(posedge clk); #1;
    model_reset(cyc);
    chk_zero("reset");
    rstn = 1'b1;

    // Single byte, then silence long enough for the burst to close.
    step(1, 8'hA5, 0, 0, 0); idle(15); chk_cnts("single");
    step(0, '0, 0, 0, 1); idle(1);

    // Back-to-back bytes: second uses skid, third overflows it.
    step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0); step(1, 8'h33, 0, 0, 0);
    idle(15); chk_cnts("skid");
    step(0, '0, 0, 0, 1); idle(1);

    // FIFO full drop, then clear.
    step(1, 8'h5A, 0, 1, 0); step(0, '0, 0, 1, 0); idle(4); chk_cnts("full");
    step(0, '0, 0, 0, 1); idle(1); chk_cnts("clear");
    chk("clear drop_cnt zero", 32'(drop_cnt), 0);

    // Frame error: dropped but not an overflow.
    step(1, 8'h77, 1, 0, 0); idle(4); chk_cnts("frame_err");
    chk("frame_err overflow low", 32'(overflow), 0);
    step(0, '0, 0, 0, 1); idle(1);

    // Burst timeout restarted by an errored byte at idle count 5.
    bs = burst_seen;
    step(1, 8'h42, 0, 0, 0); idle(7); step(1, 8'h99, 1, 0, 0); idle(20);
    chk("burst pulses", 32'(burst_seen - bs), 1);
    step(0, '0, 0, 0, 1); idle(1);

    // Counter saturation.
    for (int i = 0; i < 5; i++) begin step(1, 8'(8'hB0 + i), 0, 0, 0); idle(3); end
    idle(12); chk_cnts("saturate");
    chk("saturate wr_cnt max", 32'(wr_cnt), CMAX);

    // Reset while the write is on the bus.
    step(1, 8'hC3, 0, 0, 0); idle(1);
    rstn = 1'b0; rx_valid = 1'b0;
    @(posedge clk); #1;
    model_reset(cyc);
    chk_zero("reset_mid_wr");
    rstn = 1'b1;

    // Randomized traffic rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 120; i++) begin
        bit v, e, f;
        v = ($urandom_range(0, 99) < 40);
        e = v && ($urandom_range(0, 9) == 0);
        f = ($urandom_range(0, 4) == 0);
        step(v, 8'($urandom), e, f, 0);
      end
      idle(20); chk_cnts("random");
      step(0, '0, 0, 0, 1); idle(1);
    end

    chk("wr queue drained", 32'(exp_wr.size()), 0);
    chk("burst queue drained", 32'(exp_be.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
